// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage in front of a combinational ALU.
//
// Decodes ALUOp/funct into a 3-bit ALU control code. On accept it registers
// the operands, destination and RegWrite, and presents them to EX. A mul
// occupies EX for MUL_LAT cycles and holds busy_o high meanwhile.
//
// Optional feature macro: ALU_CTRL_CHECK_EN. When it is defined, an illegal
// R-type funct still flows through, but as an add with RegWrite suppressed,
// and it sets the sticky illegal_o flag. When it is undefined, an illegal
// funct decodes as add with RegWrite passed through, and illegal_o is 0.
//
// Ports:
//   clk_i, rst_n_i             clock (rising edge), async active-low reset
//   valid_i                    ID presents an instruction
//   ALUOp_i, funct_i           ALU operation selection
//   ALUSrc_i                   1: second operand is imm_i, 0: RTdata_i
//   RSdata_i, RTdata_i, imm_i  operand sources
//   RDaddr_i, RegWrite_i       destination and write-back enable
//   stall_i                    downstream cannot take the EX result
//   flush_i                    kill the incoming and resident instruction
//   ALUCtrl_o                  000 and, 001 or, 010 add, 011 sub, 100 mul
//   data1_o, data2_o           registered operands
//   RDaddr_o, RegWrite_o       registered destination, gated write enable
//   ex_valid_o                 EX holds a completed instruction
//   busy_o                     stage cannot accept valid_i this cycle
//   illegal_o                  sticky illegal-funct flag
module alu_issue_stage #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [5:0]  funct_i,
    input  logic        ALUSrc_i,
    input  logic [31:0] RSdata_i,
    input  logic [31:0] RTdata_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [2:0]  ALUCtrl_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [4:0]  RDaddr_o,
    output logic        RegWrite_o,
    output logic        ex_valid_o,
    output logic        busy_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StMul   = 2'b01,
        StValid = 2'b10
    } state_e;

    localparam logic [2:0] CtrlAnd = 3'b000;
    localparam logic [2:0] CtrlOr  = 3'b001;
    localparam logic [2:0] CtrlAdd = 3'b010;
    localparam logic [2:0] CtrlSub = 3'b011;
    localparam logic [2:0] CtrlMul = 3'b100;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ctrl_q;
    logic [31:0]      data1_q, data2_q;
    logic [4:0]       rd_q;
    logic             regwrite_q;

    logic [2:0]       ctrl_dec;
    logic             illegal_dec;
    logic             is_mul;
    logic             accept;
    logic             regwrite_in;

    // ALU control decode
    always_comb begin
        ctrl_dec    = CtrlAdd;
        illegal_dec = 1'b0;
        unique case (ALUOp_i)
            2'b00: ctrl_dec = CtrlAdd;
            2'b01: ctrl_dec = CtrlSub;
            2'b11: ctrl_dec = CtrlOr;
            2'b10: begin
                case (funct_i)
                    6'b100100: ctrl_dec = CtrlAnd;
                    6'b100101: ctrl_dec = CtrlOr;
                    6'b100000: ctrl_dec = CtrlAdd;
                    6'b100010: ctrl_dec = CtrlSub;
                    6'b011000: ctrl_dec = CtrlMul;
                    default: begin
                        ctrl_dec    = CtrlAdd;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            default: ctrl_dec = CtrlAdd;
        endcase
    end

    assign is_mul     = (ctrl_dec == CtrlMul);
    assign ex_valid_o = (state_q == StValid);
    assign busy_o     = (state_q == StMul) | ((state_q == StValid) & stall_i);
    assign accept     = valid_i & ~busy_o & ~flush_i;

`ifdef ALU_CTRL_CHECK_EN
    logic illegal_q;

    assign regwrite_in = RegWrite_i & ~illegal_dec;
    assign illegal_o   = illegal_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            illegal_q <= 1'b0;
        end else if (accept && illegal_dec) begin
            illegal_q <= 1'b1;
        end
    end
`else
    logic unused_illegal;

    assign unused_illegal = illegal_dec;
    assign regwrite_in    = RegWrite_i;
    assign illegal_o      = 1'b0;
`endif

    // Next-state logic. Flush overrides everything; a stalled VALID holds.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = StEmpty;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StMul: begin
                    // Counts regardless of stall; the resulting VALID honours it.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StValid;
                    end
                end
                StEmpty, StValid: begin
                    if (!((state_q == StValid) && stall_i)) begin
                        if (accept) begin
                            if (is_mul && (MUL_LAT > 1)) begin
                                state_d = StMul;
                                cnt_d   = CNT_W'(MUL_LAT - 1);
                            end else begin
                                state_d = StValid;
                            end
                        end else begin
                            state_d = StEmpty;
                        end
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload registers only change on accept, so a stall holds them stable.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q     <= 3'b000;
            data1_q    <= '0;
            data2_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
        end else if (accept) begin
            ctrl_q     <= ctrl_dec;
            data1_q    <= RSdata_i;
            data2_q    <= ALUSrc_i ? imm_i : RTdata_i;
            rd_q       <= RDaddr_i;
            regwrite_q <= regwrite_in;
        end
    end

    assign ALUCtrl_o  = ctrl_q;
    assign data1_o    = data1_q;
    assign data2_o    = data2_q;
    assign RDaddr_o   = rd_q;
    // A flushed or drained slot never requests write-back.
    assign RegWrite_o = regwrite_q & ex_valid_o;

endmodule
